// File: rtl/up_pkg.sv
// ============================================================================
// Module   : up_pkg
// Purpose  : Shared widths, depth and receiver state encoding for the loader.
// Revision : 1.0
// ============================================================================
`default_nettype none

package up_pkg;

    localparam int ADDR_W    = 8;
    localparam int DATA_W    = 8;
    localparam int MEM_DEPTH = 256;
    localparam int CNT_W     = 9;

    localparam logic [2:0] c_RX_IDLE      = 3'd0;
    localparam logic [2:0] c_RX_START     = 3'd1;
    localparam logic [2:0] c_RX_DATA      = 3'd2;
    localparam logic [2:0] c_RX_STOP      = 3'd3;
    localparam logic [2:0] c_RX_WAIT_IDLE = 3'd4;

endpackage

`default_nettype wire

// File: rtl/up_uart_rx.sv
// ============================================================================
// Module   : up_uart_rx
// Purpose  : 8N1 UART receiver with a 2-flop input synchronizer.
// Revision : 1.0
// ============================================================================
`default_nettype none

module up_uart_rx
    import up_pkg::*;
#(
    parameter int CLKS_PER_BIT = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    output logic [DATA_W-1:0] data,
    output logic              valid,
    output logic              frame_err
);

    localparam logic [15:0] c_HALF = 16'(CLKS_PER_BIT / 2);
    localparam logic [15:0] c_FULL = 16'(CLKS_PER_BIT - 1);

    logic              r_rx_meta;
    logic              r_rx_sync;
    logic [2:0]        r_state;
    logic [15:0]       r_cnt;
    logic [2:0]        r_bit;
    logic [DATA_W-1:0] r_shift;

    logic [2:0]        w_state_nxt;
    logic [15:0]       w_cnt_nxt;
    logic [2:0]        w_bit_nxt;
    logic [DATA_W-1:0] w_shift_nxt;
    logic              w_expire;
    logic              w_valid;
    logic              w_ferr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_state   <= c_RX_IDLE;
            r_cnt     <= '0;
            r_bit     <= '0;
            r_shift   <= '0;
        end else begin
            r_rx_meta <= rx;
            r_rx_sync <= r_rx_meta;
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_bit     <= w_bit_nxt;
            r_shift   <= w_shift_nxt;
        end
    end

    assign w_expire = (r_cnt == 16'd0);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_valid     = 1'b0;
        w_ferr      = 1'b0;
        case (r_state)
            c_RX_IDLE: begin
                if (!r_rx_sync) begin
                    w_state_nxt = c_RX_START;
                    w_cnt_nxt   = c_HALF;
                end
            end
            c_RX_START: begin
                // Re-check mid start bit so a short low glitch falls back to idle
                if (w_expire) begin
                    if (!r_rx_sync) begin
                        w_state_nxt = c_RX_DATA;
                        w_cnt_nxt   = c_FULL;
                        w_bit_nxt   = 3'd0;
                    end else begin
                        w_state_nxt = c_RX_IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 16'd1;
                end
            end
            c_RX_DATA: begin
                if (w_expire) begin
                    w_shift_nxt = {r_rx_sync, r_shift[DATA_W-1:1]};
                    w_cnt_nxt   = c_FULL;
                    w_bit_nxt   = r_bit + 3'd1;
                    if (r_bit == 3'd7) begin
                        w_state_nxt = c_RX_STOP;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 16'd1;
                end
            end
            c_RX_STOP: begin
                if (w_expire) begin
                    if (r_rx_sync) begin
                        w_valid     = 1'b1;
                        w_state_nxt = c_RX_IDLE;
                    end else begin
                        w_ferr      = 1'b1;
                        w_state_nxt = c_RX_WAIT_IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 16'd1;
                end
            end
            c_RX_WAIT_IDLE: begin
                if (r_rx_sync) begin
                    w_state_nxt = c_RX_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_RX_IDLE;
            end
        endcase
    end

    assign data      = r_shift;
    assign valid     = w_valid;
    assign frame_err = w_ferr;

endmodule

`default_nettype wire

// File: rtl/up_loader.sv
// ============================================================================
// Module   : up_loader
// Purpose  : UART-fed program loader driving a 256-entry memory write port.
// Revision : 1.0
// ============================================================================
`default_nettype none

module up_loader
    import up_pkg::*;
#(
    parameter int CLKS_PER_BIT = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              prog,
    input  logic              rx,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              hold,
    output logic              done,
    output logic              wrap,
    output logic              frame_err
);

    localparam logic [CNT_W-1:0]  c_CNT_FULL = CNT_W'(MEM_DEPTH);
    localparam logic [CNT_W-1:0]  c_CNT_LAST = CNT_W'(MEM_DEPTH - 1);
    localparam logic [ADDR_W-1:0] c_ADDR_ONE = ADDR_W'(1);
    localparam logic [CNT_W-1:0]  c_CNT_ONE  = CNT_W'(1);

    logic [DATA_W-1:0] w_rx_data;
    logic              w_rx_valid;
    logic              w_rx_ferr;

    logic              r_prog_d;
    logic [ADDR_W-1:0] r_addr;
    logic [CNT_W-1:0]  r_count;
    logic              r_done;
    logic              r_wrap;
    logic              r_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_ferr;

    logic              w_rise;
    logic              w_wr;
    logic [ADDR_W-1:0] w_addr_base;
    logic [CNT_W-1:0]  w_count_base;
    logic              w_done_base;
    logic              w_wrap_base;
    logic              w_count_full;

    up_uart_rx #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .data      (w_rx_data),
        .valid     (w_rx_valid),
        .frame_err (w_rx_ferr)
    );

    assign w_rise = prog & ~r_prog_d;
    assign w_wr   = w_rx_valid & prog;

    // Session start clears first, so a byte arriving on the same cycle lands at address 0
    assign w_addr_base  = w_rise ? '0 : r_addr;
    assign w_count_base = w_rise ? '0 : r_count;
    assign w_done_base  = w_rise ? 1'b0 : r_done;
    assign w_wrap_base  = w_rise ? 1'b0 : r_wrap;
    assign w_count_full = (w_count_base == c_CNT_FULL);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prog_d   <= 1'b0;
            r_addr     <= '0;
            r_count    <= '0;
            r_done     <= 1'b0;
            r_wrap     <= 1'b0;
            r_we       <= 1'b0;
            r_mem_addr <= '0;
            r_wdata    <= '0;
            r_ferr     <= 1'b0;
        end else begin
            r_prog_d <= prog;
            r_ferr   <= w_rx_ferr;
            r_we     <= 1'b0;
            r_addr   <= w_addr_base;
            r_count  <= w_count_base;
            r_done   <= w_done_base;
            r_wrap   <= w_wrap_base;
            if (w_wr) begin
                r_we       <= 1'b1;
                r_mem_addr <= w_addr_base;
                r_wdata    <= w_rx_data;
                r_addr     <= w_addr_base + c_ADDR_ONE;
                r_count    <= w_count_full ? w_count_base : w_count_base + c_CNT_ONE;
                r_done     <= w_done_base | (w_count_base == c_CNT_LAST);
                r_wrap     <= w_wrap_base | w_count_full;
            end
        end
    end

    assign mem_we    = r_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_wdata;
    assign hold      = r_prog_d;
    assign done      = r_done;
    assign wrap      = r_wrap;
    assign frame_err = r_ferr;

endmodule

`default_nettype wire
